// File: rtl/seg7_pkg.sv
// Shared types, segment constants and BCD-to-segment decode for the
// multiplexed 7-segment display driver. Segments are {a,b,c,d,e,f,g},
// active-low.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;

    // Map one BCD nibble to active-low segments; non-decimal codes go dark.
    function automatic seg_t decode_digit(input logic [3:0] code);
        seg_t s;
        case (code)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational single-digit decoder: 4-bit code to active-low segments,
// codes above 9 produce an all-off pattern.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output seg_t       seg_c
);

    // Pure table lookup shared with the package decode function.
    always_comb begin
        seg_c = decode_digit(code);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment driver.
// Scans one digit per slot of SCAN_DIV clocks, blanking all anodes for the
// first BLANK_CYCLES clocks of each slot to avoid ghosting. Loads land in a
// pending buffer and are copied to the display buffer only on frame wrap.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output seg_t                    seg_n,
    output logic                    dp_n,
    output logic                    code_err
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [BCD_W-1:0]      pend_bcd;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [BCD_W-1:0]      disp_bcd;
    logic [NUM_DIGITS-1:0] disp_dp;

    logic                  slot_end_c;
    logic                  frame_end_c;
    logic                  blank_c;
    logic [BCD_W-1:0]      pend_next_bcd_c;
    logic [NUM_DIGITS-1:0] pend_next_dp_c;
    logic                  code_err_next_c;
    logic [3:0]            digit_c;
    logic                  dp_sel_c;
    logic                  lz_blank_c;
    seg_t                  dec_seg_c;
    seg_t                  seg_sel_c;
    logic [NUM_DIGITS-1:0] anode_sel_c;

    // Slot / frame boundary detection and the pending value seen at wrap.
    always_comb begin
        slot_end_c      = (cnt == CNT_W'(SCAN_DIV - 1));
        frame_end_c     = slot_end_c && (idx == IDX_W'(NUM_DIGITS - 1));
        pend_next_bcd_c = load ? bcd_in : pend_bcd;
        pend_next_dp_c  = load ? dp_in  : pend_dp;
    end

    // Anti-ghosting window at the start of every slot.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank_c = 1'b0;
        end else begin : g_blank
            assign blank_c = (32'(cnt) < BLANK_CYCLES);
        end
    endgenerate

    // Flag any non-decimal nibble in the word being loaded.
    always_comb begin
        code_err_next_c = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                code_err_next_c = 1'b1;
            end
        end
    end

    // Select the active digit's nibble, decimal point and anode.
    always_comb begin
        digit_c     = disp_bcd[4*32'(idx) +: 4];
        dp_sel_c    = disp_dp[32'(idx)];
        anode_sel_c = ~(NUM_DIGITS'(1) << idx);
    end

    seg7_digit_decode u_decode (
        .code  (digit_c),
        .seg_c (dec_seg_c)
    );

    // Leading-zero suppression: blank digit idx>0 if it and all higher are 0.
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank_c = (idx != '0) && ((disp_bcd >> (4*32'(idx))) == '0);
    end
`else
    always_comb begin
        lz_blank_c = 1'b0;
    end
`endif

    always_comb begin
        seg_sel_c = lz_blank_c ? SEG_BLANK : dec_seg_c;
    end

    // Scan counters, double buffer, error flag and registered pin outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            idx      <= '0;
            pend_bcd <= '0;
            pend_dp  <= '0;
            disp_bcd <= '0;
            disp_dp  <= '0;
            code_err <= 1'b0;
            anode_n  <= '1;
            seg_n    <= SEG_BLANK;
            dp_n     <= 1'b1;
        end else begin
            if (slot_end_c) begin
                cnt <= '0;
                if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                    idx <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (load) begin
                pend_bcd <= bcd_in;
                pend_dp  <= dp_in;
                code_err <= code_err_next_c;
            end

            if (frame_end_c) begin
                disp_bcd <= pend_next_bcd_c;
                disp_dp  <= pend_next_dp_c;
            end

            if (blank_c) begin
                anode_n <= '1;
                seg_n   <= SEG_BLANK;
                dp_n    <= 1'b1;
            end else begin
                anode_n <= anode_sel_c;
                seg_n   <= seg_sel_c;
                dp_n    <= ~dp_sel_c;
            end
        end
    end

endmodule
